// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin share of one 16x16 multiplier
// two-stage pipe (operands, product) with a tagged response channel
module mult_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [16*N_REQ-1:0]  req_mplier,
  input  logic [16*N_REQ-1:0]  req_mcand,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_product,
  output logic                 busy
);

  typedef struct packed {
    logic [15:0]     mplier;
    logic [15:0]     mcand;
    logic [ID_W-1:0] id;
  } s1_t;

  s1_t             s1_q;
  logic            s1_valid;
  logic            s2_valid;
  logic [31:0]     s2_prod;
  logic [ID_W-1:0] s2_id;
  logic [ID_W-1:0] ptr;

  logic            adv1;
  logic            adv2;
  logic            acc;
  logic [ID_W-1:0] win;
  logic [N_REQ-1:0] grant;

  assign adv2 = !s2_valid || rsp_ready;
  assign adv1 = !s1_valid || adv2;

  // scan upward from ptr+1 so the last winner has lowest priority
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    win   = ptr;
    acc   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!acc && req_valid[idx]) begin
        acc        = 1'b1;
        win        = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
    if (!adv1 || !rst_n) begin
      grant = '0;
      acc   = 1'b0;
    end
  end

  assign req_ready = grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_id    <= '0;
      ptr      <= ID_W'(N_REQ - 1);
    end else begin
      if (adv1) begin
        s1_valid <= acc;
        if (acc) begin
          s1_q.mplier <= req_mplier[win*16 +: 16];
          s1_q.mcand  <= req_mcand[win*16 +: 16];
          s1_q.id     <= win;
          ptr         <= win;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        s2_prod  <= {16'b0, s1_q.mplier} * {16'b0, s1_q.mcand};
        s2_id    <= s1_q.id;
      end
    end
  end

  assign rsp_valid   = s2_valid;
  assign rsp_id      = s2_id;
  assign rsp_product = s2_prod;
  assign busy        = s1_valid || s2_valid;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed steps with an accept-time
// scoreboard checked against each response transfer
module tb_mult_share_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  typedef struct packed {
    logic [W-1:0] id;
    logic [31:0]  prod;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [16*N-1:0]  req_mplier;
  logic [16*N-1:0]  req_mcand;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_id;
  logic [31:0]      rsp_product;
  logic             busy;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  mult_share_arbiter #(.N_REQ(N), .ID_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mplier  (req_mplier),
    .req_mcand   (req_mcand),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a,
                        input logic [15:0] b);
    req_mplier[i*16 +: 16] = a;
    req_mcand[i*16 +: 16]  = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++)
      set_op(i, 16'($urandom), 16'($urandom));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // one cycle; drops valid for requesters accepted this cycle
  task automatic cyc(output logic [N-1:0] r);
    @(negedge clk);
    r = req_ready & req_valid;
    step();
    req_valid = req_valid & ~r;
  endtask

  task automatic drain(input string tag);
    int n;
    for (n = 0; n < 60; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) break;
    end
    chk({tag, "_drain_q"}, 64'(q.size()), 0);
    chk({tag, "_drain_busy"}, busy, 0);
    step();
  endtask

  task automatic send_one(input int i, input logic [15:0] a,
                          input logic [15:0] b,
                          input logic [31:0] exp, input string tag);
    int n;
    set_op(i, a, b);
    req_valid[i] = 1'b1;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    chk({tag, "_accept"}, req_ready[i], 1);
    step();
    req_valid[i] = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_prod"}, rsp_product, exp);
    chk({tag, "_id"}, rsp_id, W'(i));
    step();
  endtask

  // scoreboard: push on accept, pop on transfer, watch stalls
  initial begin
    logic          hold;
    logic [W-1:0]  h_id;
    logic [31:0]   h_prod;
    exp_t          e;
    hold   = 1'b0;
    h_id   = '0;
    h_prod = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        hold = 1'b0;
      end else begin
        chk("onehot", 64'($countones(req_ready) <= 1), 1);
        if (hold) begin
          chk("stall_valid", rsp_valid, 1);
          chk("stall_id", rsp_id, h_id);
          chk("stall_prod", rsp_product, h_prod);
        end
        if (rsp_valid && rsp_ready) begin
          if (q.size() == 0) begin
            chk("stale_rsp", rsp_valid, 0);
          end else begin
            e = q.pop_front();
            chk("sb_id", rsp_id, e.id);
            chk("sb_prod", rsp_product, e.prod);
          end
        end
        for (int i = 0; i < N; i++)
          if (req_valid[i] && req_ready[i]) begin
            e.id   = W'(i);
            e.prod = 32'(req_mplier[i*16 +: 16]) *
                     32'(req_mcand[i*16 +: 16]);
            q.push_back(e);
          end
        hold   = rsp_valid && !rsp_ready;
        h_id   = rsp_id;
        h_prod = rsp_product;
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    logic [3:0]   ex;
    int           cnt;
    rst_n      = 1'b0;
    req_valid  = '1;
    rsp_ready  = 1'b1;
    req_mplier = '0;
    req_mcand  = '0;
    rand_ops();

    // reset state, requests held high during reset
    repeat (2) step();
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_prod", rsp_product, 0);
    chk("rst_id", rsp_id, 0);
    step();
    rst_n     = 1'b1;
    req_valid = '0;

    // single request and latency
    set_op(0, 16'd3, 16'd5);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("lat1_valid", rsp_valid, 0);
    chk("lat1_busy", busy, 1);
    @(negedge clk);
    chk("lat2_valid", rsp_valid, 1);
    chk("single_prod", rsp_product, 32'd15);
    chk("single_id", rsp_id, 0);
    @(negedge clk);
    chk("single_idle_busy", busy, 0);
    chk("single_idle_valid", rsp_valid, 0);
    step();

    // width extremes
    send_one(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "ext_ff");
    send_one(1, 16'h0000, 16'hABCD, 32'h00000000, "ext_zero");
    send_one(1, 16'h8000, 16'h0002, 32'h00010000, "ext_msb");

    // fairness: all valid, one grant per cycle in rotation
    do_reset();
    rand_ops();
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ex = 4'(1 << (k % 4));
      chk("fair_grant", req_ready, ex);
      step();
      rand_ops();
    end
    req_valid = '0;
    drain("fair");

    // backpressure: at most two accepts while stalled
    rsp_ready = 1'b0;
    rand_ops();
    req_valid = '1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k >= 2) chk("bp_ready_zero", req_ready, 0);
      r = req_ready & req_valid;
      cnt += $countones(r);
      step();
      req_valid = req_valid & ~r;
    end
    chk("bp_accepts", 64'(cnt), 2);
    rsp_ready = 1'b1;
    for (int n = 0; n < 40 && req_valid != '0; n++) cyc(r);
    chk("bp_all_accepted", req_valid, 0);
    drain("bp");

    // rotation: 3 transfers from 2, then 3 beats 0
    cnt = 0;
    req_valid = 4'b0100;
    for (int n = 0; n < 30 && cnt < 3; n++) begin
      @(negedge clk);
      cnt += $countones(req_ready & req_valid);
      step();
      set_op(2, 16'($urandom), 16'($urandom));
    end
    chk("rot_count", 64'(cnt), 3);
    req_valid = 4'b1001;
    @(negedge clk);
    chk("rot_first", req_ready, 4'b1000);
    r = req_ready & req_valid;
    step();
    req_valid = req_valid & ~r;
    @(negedge clk);
    chk("rot_second", req_ready, 4'b0001);
    step();
    req_valid = '0;
    drain("rot");

    // reset with both stages full
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(r);
      cnt += $countones(r);
    end
    chk("mid_accepts", 64'(cnt), 2);
    @(negedge clk);
    chk("mid_full_busy", busy, 1);
    chk("mid_full_valid", rsp_valid, 1);
    step();
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1001;
    @(negedge clk);
    chk("mid_rst_ready", req_ready, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_post_valid", rsp_valid, 0);
    chk("mid_post_busy", busy, 0);
    chk("mid_post_prio", req_ready, 4'b0001);
    step();
    for (int n = 0; n < 20 && req_valid != '0; n++) cyc(r);
    chk("mid_all_accepted", req_valid, 0);
    drain("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
